// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// Owns the program counter, drives it to a combinational instruction memory
// and latches the returned word into the IF/ID pipeline register.
//
// The next PC comes from one of three sources:
//   - sequential PC+4
//   - a redirect target from downstream (taken branch or jr), which also
//     flushes IF/ID
//   - optionally, an early-resolved `j` target
//
// Stall freezes both the PC and IF/ID. Redirect overrides Stall, and reset
// overrides everything.
//
// Build option:
//   FETCH_EARLY_JUMP_EN  When defined, a `j` (opcode 000010) is resolved here
//                        and squashed, so it never reaches IF/ID. When not
//                        defined, `j` is latched like any other instruction
//                        and downstream must redirect for it.
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00400000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] PC_Address,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic        IFID_Valid,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_PCPlus4
);

    // Architectural state and its next-state values
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        ifid_valid_reg;
    logic        ifid_valid_next;
    logic [31:0] ifid_instr_reg;
    logic [31:0] ifid_instr_next;
    logic [31:0] ifid_pc_reg;
    logic [31:0] ifid_pc_next;
    logic [31:0] ifid_pc_plus4_reg;
    logic [31:0] ifid_pc_plus4_next;

    // Sequential successor of the current PC. It wraps silently at 2^32.
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_reg + 32'd4;

    // Redirect targets are forced to word alignment. The low bits are
    // intentionally dropped.
    logic [31:0] redirect_aligned;
    logic [1:0]  unused_redirect_low;
    assign redirect_aligned    = {RedirectTarget[31:2], 2'b00};
    assign unused_redirect_low = RedirectTarget[1:0];

    // Early jump detection. The target uses the region bits of the jump's
    // own PC+4, as the MIPS `j` semantics require.
    logic        take_jump;
    logic [31:0] jump_target;
`ifdef FETCH_EARLY_JUMP_EN
    localparam logic [5:0] OPC_J = 6'b000010;
    assign take_jump   = (Instruction[31:26] == OPC_J);
    assign jump_target = {pc_plus4[31:28], Instruction[25:0], 2'b00};
`else
    assign take_jump   = 1'b0;
    assign jump_target = pc_plus4;
`endif

    // Next-state selection: redirect > stall > early jump > sequential fetch
    always_comb begin
        pc_next            = pc_reg;
        ifid_valid_next    = ifid_valid_reg;
        ifid_instr_next    = ifid_instr_reg;
        ifid_pc_next       = ifid_pc_reg;
        ifid_pc_plus4_next = ifid_pc_plus4_reg;

        if (Redirect) begin
            // Flush the wrong-path entry and refetch from the aligned target
            pc_next            = redirect_aligned;
            ifid_valid_next    = 1'b0;
            ifid_instr_next    = 32'd0;
            ifid_pc_next       = 32'd0;
            ifid_pc_plus4_next = 32'd0;
        end else if (!Stall) begin
            if (take_jump) begin
                // The `j` does its whole job here, so it becomes a bubble
                pc_next            = jump_target;
                ifid_valid_next    = 1'b0;
                ifid_instr_next    = 32'd0;
                ifid_pc_next       = 32'd0;
                ifid_pc_plus4_next = 32'd0;
            end else begin
                pc_next            = pc_plus4;
                ifid_valid_next    = 1'b1;
                ifid_instr_next    = Instruction;
                ifid_pc_next       = pc_reg;
                ifid_pc_plus4_next = pc_plus4;
            end
        end
    end

    // State registers. Reset wins over every other request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg            <= RESET_PC;
            ifid_valid_reg    <= 1'b0;
            ifid_instr_reg    <= 32'd0;
            ifid_pc_reg       <= 32'd0;
            ifid_pc_plus4_reg <= 32'd0;
        end else begin
            pc_reg            <= pc_next;
            ifid_valid_reg    <= ifid_valid_next;
            ifid_instr_reg    <= ifid_instr_next;
            ifid_pc_reg       <= ifid_pc_next;
            ifid_pc_plus4_reg <= ifid_pc_plus4_next;
        end
    end

    assign PC_Address       = pc_reg;
    assign IFID_Valid       = ifid_valid_reg;
    assign IFID_Instruction = ifid_instr_reg;
    assign IFID_PC          = ifid_pc_reg;
    assign IFID_PCPlus4     = ifid_pc_plus4_reg;

endmodule
